// File: rtl/draw_circle_multi.sv
// draw_circle_multi: double-buffered multi-slot circle renderer with a 4-stage pixel pipeline.
// Defining DRAW_CIRCLE_MULTI_RING_EN adds per-slot outline (ring) mode.
module draw_circle_multi #(
    parameter int          NUM_CIRCLES    = 4,
    parameter int          H_BITS         = 11,
    parameter int          V_BITS         = 10,
    parameter logic [23:0] BG_COLOR       = 24'h00_00_00,
    parameter int          RING_THICKNESS = 2,
    localparam int         IW             = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic              pixel_valid_in,
    input  logic              frame_start_in,
    input  logic              wr_valid_in,
    input  logic [IW-1:0]     wr_idx_in,
    input  logic [H_BITS-1:0] wr_x1_in,
    input  logic [H_BITS-1:0] wr_x2_in,
    input  logic [V_BITS-1:0] wr_y1_in,
    input  logic [V_BITS-1:0] wr_y2_in,
    input  logic [23:0]       wr_color_in,
    input  logic              wr_en_in,
    input  logic              wr_ring_in,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              hit_out,
    output logic [IW-1:0]     hit_idx_out,
    output logic              pixel_valid_out
);
    localparam int C = (H_BITS > V_BITS) ? H_BITS : V_BITS;
    localparam int W = 2 * C;

    typedef struct packed {
        logic [H_BITS-1:0] r;
        logic [H_BITS-1:0] cx;
        logic [V_BITS-1:0] cy;
        logic [23:0]       col;
        logic              en;
`ifdef DRAW_CIRCLE_MULTI_RING_EN
        logic              ring;
`endif
    } slot_t;

    slot_t             sh  [NUM_CIRCLES];
    slot_t             act [NUM_CIRCLES];
    slot_t             nw;
    logic              n_v;
    logic [IW-1:0]     n_idx;
    logic [H_BITS-1:0] n_xlo, n_xhi;
    logic [V_BITS-1:0] n_ylo, n_yhi;
    logic [23:0]       n_col;
    logic              n_en;
`ifdef DRAW_CIRCLE_MULTI_RING_EN
    logic              n_ring;
`else
    logic              unused_ring;
    assign unused_ring = wr_ring_in ^ RING_THICKNESS[0];
`endif

    always_comb begin
        nw     = '0;
        nw.r   = (n_xhi - n_xlo) >> 1;
        nw.cx  = H_BITS'(({1'b0, n_xlo} + {1'b0, n_xhi}) >> 1);
        nw.cy  = V_BITS'(({1'b0, n_ylo} + {1'b0, n_yhi}) >> 1);
        nw.col = n_col;
        nw.en  = n_en;
`ifdef DRAW_CIRCLE_MULTI_RING_EN
        nw.ring = n_ring;
`endif
    end

    // Commit copies the shadow as it stood before this edge's shadow store.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            n_v   <= 1'b0;
            n_idx <= '0;
            n_xlo <= '0;
            n_xhi <= '0;
            n_ylo <= '0;
            n_yhi <= '0;
            n_col <= '0;
            n_en  <= 1'b0;
`ifdef DRAW_CIRCLE_MULTI_RING_EN
            n_ring <= 1'b0;
`endif
            for (int i = 0; i < NUM_CIRCLES; i++) begin
                sh[i]  <= '0;
                act[i] <= '0;
            end
        end else begin
            n_v   <= wr_valid_in && (int'(wr_idx_in) < NUM_CIRCLES);
            n_idx <= wr_idx_in;
            n_xlo <= (wr_x1_in < wr_x2_in) ? wr_x1_in : wr_x2_in;
            n_xhi <= (wr_x1_in < wr_x2_in) ? wr_x2_in : wr_x1_in;
            n_ylo <= (wr_y1_in < wr_y2_in) ? wr_y1_in : wr_y2_in;
            n_yhi <= (wr_y1_in < wr_y2_in) ? wr_y2_in : wr_y1_in;
            n_col <= wr_color_in;
            n_en  <= wr_en_in;
`ifdef DRAW_CIRCLE_MULTI_RING_EN
            n_ring <= wr_ring_in;
`endif
            if (n_v) sh[n_idx] <= nw;
            if (frame_start_in) act <= sh;
        end
    end

    logic              v1, v2, v3;
    logic [C-1:0]      dx_c   [NUM_CIRCLES];
    logic [C-1:0]      dy_c   [NUM_CIRCLES];
    logic [C-1:0]      s1_dx  [NUM_CIRCLES];
    logic [C-1:0]      s1_dy  [NUM_CIRCLES];
    logic [H_BITS-1:0] s1_r   [NUM_CIRCLES];
    logic              s1_en  [NUM_CIRCLES];
    logic [23:0]       s1_col [NUM_CIRCLES];
    logic [W-1:0]      s2_dx2 [NUM_CIRCLES];
    logic [W-1:0]      s2_dy2 [NUM_CIRCLES];
    logic [W-1:0]      s2_r2  [NUM_CIRCLES];
    logic              s2_en  [NUM_CIRCLES];
    logic [23:0]       s2_col [NUM_CIRCLES];
    logic [W:0]        sum_c  [NUM_CIRCLES];
    logic              hit_c  [NUM_CIRCLES];
    logic              s3_hit [NUM_CIRCLES];
    logic [23:0]       s3_col [NUM_CIRCLES];
`ifdef DRAW_CIRCLE_MULTI_RING_EN
    logic              s1_ring [NUM_CIRCLES];
    logic [H_BITS-1:0] rt_c    [NUM_CIRCLES];
    logic [W-1:0]      s2_rt2  [NUM_CIRCLES];
    logic              s2_ring [NUM_CIRCLES];
`endif
    logic              sel_hit;
    logic [IW-1:0]     sel_idx;
    logic [23:0]       sel_col;
    logic [23:0]       rgb;

    always_comb begin
        for (int i = 0; i < NUM_CIRCLES; i++) begin
            dx_c[i]  = C'((hcount_in >= act[i].cx) ? hcount_in - act[i].cx : act[i].cx - hcount_in);
            dy_c[i]  = C'((vcount_in >= act[i].cy) ? vcount_in - act[i].cy : act[i].cy - vcount_in);
            sum_c[i] = {1'b0, s2_dx2[i]} + {1'b0, s2_dy2[i]};
            hit_c[i] = s2_en[i] && (sum_c[i] <= {1'b0, s2_r2[i]});
`ifdef DRAW_CIRCLE_MULTI_RING_EN
            rt_c[i]  = s1_r[i] - H_BITS'(RING_THICKNESS);
            hit_c[i] = hit_c[i] && (!s2_ring[i] || sum_c[i] > {1'b0, s2_rt2[i]});
`endif
        end
    end

    // Lowest index wins: scan downward so the last match kept is the smallest.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_col = BG_COLOR;
        for (int i = NUM_CIRCLES - 1; i >= 0; i--) begin
            if (s3_hit[i]) begin
                sel_hit = 1'b1;
                sel_idx = IW'(i);
                sel_col = s3_col[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1              <= 1'b0;
            v2              <= 1'b0;
            v3              <= 1'b0;
            rgb             <= BG_COLOR;
            hit_out         <= 1'b0;
            hit_idx_out     <= '0;
            pixel_valid_out <= 1'b0;
            for (int i = 0; i < NUM_CIRCLES; i++) begin
                s1_dx[i]  <= '0;
                s1_dy[i]  <= '0;
                s1_r[i]   <= '0;
                s1_en[i]  <= 1'b0;
                s1_col[i] <= '0;
                s2_dx2[i] <= '0;
                s2_dy2[i] <= '0;
                s2_r2[i]  <= '0;
                s2_en[i]  <= 1'b0;
                s2_col[i] <= '0;
                s3_hit[i] <= 1'b0;
                s3_col[i] <= '0;
`ifdef DRAW_CIRCLE_MULTI_RING_EN
                s1_ring[i] <= 1'b0;
                s2_rt2[i]  <= '0;
                s2_ring[i] <= 1'b0;
`endif
            end
        end else begin
            v1 <= pixel_valid_in;
            v2 <= v1;
            v3 <= v2;
            for (int i = 0; i < NUM_CIRCLES; i++) begin
                s1_dx[i]  <= dx_c[i];
                s1_dy[i]  <= dy_c[i];
                s1_r[i]   <= act[i].r;
                s1_en[i]  <= act[i].en;
                s1_col[i] <= act[i].col;
                s2_dx2[i] <= W'(s1_dx[i]) * W'(s1_dx[i]);
                s2_dy2[i] <= W'(s1_dy[i]) * W'(s1_dy[i]);
                s2_r2[i]  <= W'(s1_r[i]) * W'(s1_r[i]);
                s2_en[i]  <= s1_en[i];
                s2_col[i] <= s1_col[i];
                s3_hit[i] <= v2 && hit_c[i];
                s3_col[i] <= s2_col[i];
`ifdef DRAW_CIRCLE_MULTI_RING_EN
                s1_ring[i] <= act[i].ring;
                s2_rt2[i]  <= W'(rt_c[i]) * W'(rt_c[i]);
                s2_ring[i] <= s1_ring[i] && (int'(s1_r[i]) > RING_THICKNESS);
`endif
            end
            rgb             <= sel_col;
            hit_out         <= sel_hit;
            hit_idx_out     <= sel_idx;
            pixel_valid_out <= v3;
        end
    end

    assign red_out   = rgb[23:16];
    assign green_out = rgb[15:8];
    assign blue_out  = rgb[7:0];
endmodule

// File: tb/tb_draw_circle_multi.sv
// tb_draw_circle_multi: directed and randomized checks of draw_circle_multi against a
// geometric reference model (distance test per committed circle, lowest index first).
module tb_draw_circle_multi;
    localparam int          N  = 3;
    localparam int          T  = 2;
    localparam logic [23:0] BG = 24'h102030;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        pixel_valid_in = 1'b0;
    logic        frame_start_in = 1'b0;
    logic        wr_valid_in = 1'b0;
    logic [1:0]  wr_idx_in = '0;
    logic [10:0] wr_x1_in = '0;
    logic [10:0] wr_x2_in = '0;
    logic [9:0]  wr_y1_in = '0;
    logic [9:0]  wr_y2_in = '0;
    logic [23:0] wr_color_in = '0;
    logic        wr_en_in = 1'b0;
    logic        wr_ring_in = 1'b0;
    logic [7:0]  red_out, green_out, blue_out;
    logic        hit_out;
    logic [1:0]  hit_idx_out;
    logic        pixel_valid_out;
    logic [27:0] obs;

    int errors = 0;
    int checks = 0;

    draw_circle_multi #(
        .NUM_CIRCLES(N), .H_BITS(11), .V_BITS(10), .BG_COLOR(BG), .RING_THICKNESS(T)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_valid_in(pixel_valid_in), .frame_start_in(frame_start_in),
        .wr_valid_in(wr_valid_in), .wr_idx_in(wr_idx_in), .wr_x1_in(wr_x1_in),
        .wr_x2_in(wr_x2_in), .wr_y1_in(wr_y1_in), .wr_y2_in(wr_y2_in),
        .wr_color_in(wr_color_in), .wr_en_in(wr_en_in), .wr_ring_in(wr_ring_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .hit_out(hit_out),
        .hit_idx_out(hit_idx_out), .pixel_valid_out(pixel_valid_out)
    );

    assign obs = {red_out, green_out, blue_out, hit_out, hit_idx_out, pixel_valid_out};

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cx;
        int          cy;
        int          r;
        logic [23:0] col;
        bit          en;
        bit          ring;
    } circ_t;

    circ_t       sh [N];
    circ_t       act [N];
    circ_t       pend;
    bit          pend_v = 1'b0;
    int          pend_idx = 0;
    logic [27:0] q [$];

    function automatic bit covers(circ_t c, int h, int v);
        int d;
        bit in;
        d  = (h - c.cx) * (h - c.cx) + (v - c.cy) * (v - c.cy);
        in = c.en && (d <= c.r * c.r);
`ifdef DRAW_CIRCLE_MULTI_RING_EN
        if (c.ring && c.r > T) in = in && (d > (c.r - T) * (c.r - T));
`endif
        return in;
    endfunction

    function automatic logic [27:0] expect_px(int h, int v, bit val);
        if (val)
            for (int i = 0; i < N; i++)
                if (covers(act[i], h, v)) return {act[i].col, 1'b1, 2'(i), 1'b1};
        return {BG, 1'b0, 2'b00, val};
    endfunction

    task automatic check(string tag, logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got rgb/hit/idx/pv=%h want %h", tag, obs, exp);
        end
    endtask

    // One clock: record the expected output for the pixel now driven, advance the model
    // across the edge, then compare whatever pixel has just left the 4-cycle pipe.
    task automatic tick();
        int x1, x2, y1, y2;
        q.push_back(expect_px(int'(hcount_in), int'(vcount_in), pixel_valid_in));
        if (frame_start_in) act = sh;
        if (pend_v) sh[pend_idx] = pend;
        x1 = int'(wr_x1_in);
        x2 = int'(wr_x2_in);
        y1 = int'(wr_y1_in);
        y2 = int'(wr_y2_in);
        pend_v    = wr_valid_in && (int'(wr_idx_in) < N);
        pend_idx  = int'(wr_idx_in);
        pend.cx   = (x1 + x2) / 2;
        pend.cy   = (y1 + y2) / 2;
        pend.r    = ((x1 > x2) ? x1 - x2 : x2 - x1) / 2;
        pend.col  = wr_color_in;
        pend.en   = wr_en_in;
        pend.ring = wr_ring_in;
        @(posedge clk_in);
        #1;
        if (q.size() == 4) check("pixel", q.pop_front());
        frame_start_in = 1'b0;
        wr_valid_in    = 1'b0;
        pixel_valid_in = 1'b0;
    endtask

    task automatic wr(int idx, int x1, int x2, int y1, int y2, logic [23:0] col, bit en, bit ring, bit fs);
        wr_valid_in    = 1'b1;
        wr_idx_in      = 2'(idx);
        wr_x1_in       = 11'(x1);
        wr_x2_in       = 11'(x2);
        wr_y1_in       = 10'(y1);
        wr_y2_in       = 10'(y2);
        wr_color_in    = col;
        wr_en_in       = en;
        wr_ring_in     = ring;
        frame_start_in = fs;
        tick();
    endtask

    task automatic commit();
        tick();
        frame_start_in = 1'b1;
        tick();
    endtask

    task automatic probe(string tag, int h, int v, bit eh, logic [23:0] ergb, int eidx);
        hcount_in      = 11'(h);
        vcount_in      = 10'(v);
        pixel_valid_in = 1'b1;
        repeat (4) tick();
        check(tag, {ergb, eh, 2'(eidx), 1'b1});
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh[i]  = '{0, 0, 0, 24'h0, 1'b0, 1'b0};
            act[i] = '{0, 0, 0, 24'h0, 1'b0, 1'b0};
        end
        pend_v = 1'b0;
        q.delete();
    endtask

    initial begin
        model_reset();
        #2 rst_n_in = 1'b0;
        #1 check("reset_async", {BG, 4'b0});
        @(posedge clk_in);
        #1 check("reset_hold", {BG, 4'b0});
        rst_n_in = 1'b1;

        wr(0, 120, 100, 70, 50, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        probe("uncommitted", 110, 60, 1'b0, BG, 0);
        commit();
        probe("centre", 110, 60, 1'b1, 24'hFF0000, 0);
        probe("edge_x", 120, 60, 1'b1, 24'hFF0000, 0);
        probe("out_x", 121, 60, 1'b0, BG, 0);
        probe("in_diag", 117, 67, 1'b1, 24'hFF0000, 0);
        probe("out_diag", 118, 67, 1'b0, BG, 0);

        hcount_in = 11'd110;
        vcount_in = 10'd60;
        repeat (4) tick();
        check("invalid_px", {BG, 4'b0});

        wr(1, 105, 125, 50, 70, 24'h00FF00, 1'b1, 1'b0, 1'b0);
        commit();
        probe("prio_low", 112, 60, 1'b1, 24'hFF0000, 0);
        probe("prio_slot1", 124, 60, 1'b1, 24'h00FF00, 1);

        wr(2, 220, 200, 100, 120, 24'h0000FF, 1'b1, 1'b0, 1'b1);
        probe("same_edge_old", 210, 110, 1'b0, BG, 0);
        commit();
        probe("same_edge_new", 210, 110, 1'b1, 24'h0000FF, 2);

        wr(N, 40, 60, 40, 60, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
        commit();
        probe("bad_idx_none", 50, 50, 1'b0, BG, 0);
        probe("bad_idx_keep", 110, 60, 1'b1, 24'hFF0000, 0);

        wr(0, 120, 100, 70, 50, 24'hFF0000, 1'b1, 1'b1, 1'b0);
        wr(1, 105, 125, 50, 70, 24'h00FF00, 1'b0, 1'b0, 1'b0);
        commit();
`ifdef DRAW_CIRCLE_MULTI_RING_EN
        probe("ring_centre", 110, 60, 1'b0, BG, 0);
        probe("ring_inner", 118, 60, 1'b0, BG, 0);
`else
        probe("ring_centre", 110, 60, 1'b1, 24'hFF0000, 0);
        probe("ring_inner", 118, 60, 1'b1, 24'hFF0000, 0);
`endif
        probe("ring_81", 119, 60, 1'b1, 24'hFF0000, 0);
        probe("ring_outer", 120, 60, 1'b1, 24'hFF0000, 0);

        for (int k = 0; k < N; k++)
            wr(k, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), 24'($urandom), $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), 1'b0);
        commit();
        for (int k = 0; k < 400; k++) begin
            hcount_in      = 11'($urandom_range(0, 255));
            vcount_in      = 10'($urandom_range(0, 255));
            pixel_valid_in = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 9) == 0) begin
                wr_valid_in = 1'b1;
                wr_idx_in   = 2'($urandom_range(0, 3));
                wr_x1_in    = 11'($urandom_range(0, 255));
                wr_x2_in    = 11'($urandom_range(0, 255));
                wr_y1_in    = 10'($urandom_range(0, 255));
                wr_y2_in    = 10'($urandom_range(0, 255));
                wr_color_in = 24'($urandom);
                wr_en_in    = $urandom_range(0, 3) != 0;
                wr_ring_in  = 1'($urandom_range(0, 1));
            end
            frame_start_in = $urandom_range(0, 19) == 0;
            tick();
        end

        wr(0, 120, 100, 70, 50, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        commit();
        for (int k = 0; k < 6; k++) begin
            hcount_in      = 11'(108 + k);
            vcount_in      = 10'd60;
            pixel_valid_in = 1'b1;
            tick();
        end
        rst_n_in = 1'b0;
        model_reset();
        #1 check("rst_mid_async", {BG, 4'b0});
        @(posedge clk_in);
        #1 check("rst_mid_hold", {BG, 4'b0});
        rst_n_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            hcount_in      = 11'($urandom_range(100, 130));
            vcount_in      = 10'($urandom_range(50, 70));
            pixel_valid_in = 1'b1;
            tick();
        end
        wr(0, 120, 100, 70, 50, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        commit();
        probe("recover", 110, 60, 1'b1, 24'hFF0000, 0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/draw_circle_multi.md
Name: draw_circle_multi

Overview:
- Parametrised multi-slot circle renderer; successor to the single-circle pixel generator in the video overlay path.
- Holds NUM_CIRCLES independent circles, each with its own colour and enable, defined by a bounding pair of points.
- Double-buffered: shadow slots are written at any time and committed to active slots only on a frame-start pulse, which prevents tearing.
- Sits between the hcount/vcount timing generator and the overlay mixer. Produces RGB plus hit and index flags at a fixed latency.

Parameters:
- NUM_CIRCLES, 4, number of circle slots (1..16).
- H_BITS, 11, width of hcount and all x coordinates.
- V_BITS, 10, width of vcount and all y coordinates.
- BG_COLOR, 24'h00_00_00, RGB driven when no slot hits or the pixel is invalid.
- RING_THICKNESS, 2, outline thickness in pixels; used only when DRAW_CIRCLE_MULTI_RING_EN is defined.

Ports:
- clk_in  input  1  pixel clock; single clock domain.
- rst_n_in  input  1  asynchronous, active-low reset.
- hcount_in  input  H_BITS  current pixel x.
- vcount_in  input  V_BITS  current pixel y.
- pixel_valid_in  input  1  hcount_in/vcount_in are in the active area.
- frame_start_in  input  1  one-cycle pulse; commits shadow slots to active slots.
- wr_valid_in  input  1  slot write strobe.
- wr_idx_in  input  $clog2(NUM_CIRCLES) (min 1)  target slot.
- wr_x1_in, wr_x2_in  input  H_BITS  bounding x points, in any order.
- wr_y1_in, wr_y2_in  input  V_BITS  bounding y points, in any order.
- wr_color_in  input  24  slot RGB.
- wr_en_in  input  1  slot enable.
- wr_ring_in  input  1  outline mode; ignored unless the macro is defined.
- red_out, green_out, blue_out  output  8 each  pixel colour.
- hit_out  output  1  some enabled slot covers this pixel.
- hit_idx_out  output  $clog2(NUM_CIRCLES) (min 1)  winning slot index; 0 when no hit.
- pixel_valid_out  output  1  pixel_valid_in delayed to align with the pixel outputs.

Behaviour:
- Reset:
  - All shadow and active slots cleared (enable=0).
  - Pipeline valid flags cleared.
  - RGB outputs = BG_COLOR; hit_out=0, hit_idx_out=0, pixel_valid_out=0.
  - Reset asserted mid-frame clears everything immediately.
- Slot write, accepted every cycle; a write with wr_idx_in >= NUM_CIRCLES is ignored.
  - Cycle t: capture the inputs and normalise: x_lo=min(x1,x2), x_hi=max(x1,x2); same for y.
  - Cycle t+1: store into the shadow slot: r=(x_hi-x_lo)>>1, cx=(x_lo+x_hi)>>1, cy=(y_lo+y_hi)>>1, plus colour, enable and ring bit.
  - Back-to-back writes to the same slot: the last one wins.
- Commit: on a frame_start_in edge, every active slot is loaded from the shadow contents as they stand at that edge.
  - A write captured on the same edge, or still in normalisation, reaches the shadow only and is visible at the next commit.
- Pixel pipeline, fully pipelined (one pixel per clock), latency exactly 4 cycles: inputs at edge t, outputs valid after edge t+4.
  - S1: per slot |dx|=|hcount-cx| and |dy|=|vcount-cy|, unsigned and computed without wrap.
  - S2: dx², dy², r² at 2*H_BITS width.
  - S3: per-slot hit = enable && (dx²+dy² <= r²); the sum is 2*H_BITS+1 bits wide so it cannot overflow.
  - S4: priority select, lowest index wins; register RGB, hit_out, hit_idx_out and pixel_valid_out.
- pixel_valid_in=0 for a pixel → that pixel's outputs are BG_COLOR, hit_out=0, hit_idx_out=0.
- r=0 → the slot hits only the exact centre pixel.
- A commit during active video takes effect for pixels entering S1 after the commit edge; no partially-updated slot is ever visible.

Optional Feature:
- Macro: DRAW_CIRCLE_MULTI_RING_EN.
- Defined:
  - A slot with ring=1 hits only when dx²+dy² <= r² and dx²+dy² > (r-RING_THICKNESS)².
  - If r <= RING_THICKNESS the ring slot behaves as filled.
  - (r-T)² is computed in S2; latency is unchanged.
- Undefined:
  - The ring bit is neither stored nor used; all slots are filled.
  - RING_THICKNESS has no effect.

Test Plan:
- Reset, then write slot0 (x1=120,x2=100,y1=70,y2=50,colour FF0000,en=1) with no frame_start → pixel (110,60) gives hit_out=0 and RGB=BG. After frame_start, (110,60) → hit, RGB=FF0000, output exactly 4 cycles after input.
- Same slot committed: (120,60) hit (d²=100); (121,60) miss; (117,67) hit (98); (118,67) miss (113).
- Slot0 as above plus slot1 (cx=115,cy=60,r=10,colour 00FF00), both committed → (112,60) gives RGB=FF0000, hit_idx=0; (124,60) gives 00FF00, hit_idx=1.
- Write and frame_start on the same edge → old active contents persist; the new circle appears only after the next frame_start. Writes with wr_idx_in=NUM_CIRCLES change nothing.
- With the macro, slot0 ring=1: (110,60) miss, (118,60) miss (64), (119,60) hit (81), (120,60) hit. Without the macro, all four hit.
- Assert rst_n_in mid-stream with slots active → outputs are BG, hit_out=0, pixel_valid_out=0 immediately. After release, no slot hits until a rewrite and commit.
